arith_accum_unit: RTL and testbench
===================================

// Module: arith_accum_unit
// PURPOSE
//  Parametrised, registered signed add/sub unit with a running accumulator.
//  Successor to the 8-bit combinational add/sub-with-overflow datapath.
//  Adds operand width, accumulate modes, a valid/ready handshake and a
//  saturating overflow event counter. Sits between switch/host operand
//  capture and the LED/display stage.
// PARAMETERS
//  WIDTH  8  operand, result and accumulator width (two's complement, >=2)
//  CNT_W  4  width of the overflow event counter (>=1)
// PORTS
//  clk         in   1      system clock; all state updates on rising edge
//  reset_n     in   1      synchronous, active-low reset
//  in_valid    in   1      op/a/b valid this cycle
//  in_ready    out  1      unit can accept an op this cycle
//  op          in   2      00 a+b, 01 a-b, 10 acc+a, 11 acc-a
//  a           in   WIDTH  operand A (signed)
//  b           in   WIDTH  operand B (signed); ignored for op 10/11
//  out_valid   out  1      result/overflow valid
//  out_ready   in   1      consumer takes result this cycle
//  result      out  WIDTH  registered result
//  overflow    out  1      signed overflow of the op that produced result
//  acc         out  WIDTH  accumulator (equals last accepted result)
//  ovf_count   out  CNT_W  saturating count of accepted ops that overflowed
//  clr_count   in   1      synchronous clear of ovf_count
// BEHAVIOUR
//  - Reset (reset_n=0 at edge): out_valid=0, result=0, overflow=0, acc=0,
//    ovf_count=0. in_ready=0 while reset_n=0. Reset mid-op drops in-flight result.
//  - in_ready = reset_n & (~out_valid | out_ready), combinational.
//  - Accept = in_valid & in_ready. On accept: result, overflow, acc load
//    the new value next edge; out_valid=1. Latency 1 cycle. Throughput 1/cycle.
//  - out_valid holds, result/overflow stay stable, until out_valid & out_ready.
//    Pop with no accept -> out_valid=0, result and acc keep their values.
//  - Pop and accept in the same cycle -> the new result replaces the old one and
//    out_valid stays 1.
//  - Arithmetic: X = (op[1] ? acc : a), Y = (op[1] ? a : b).
//    Compute sum = X + (op[0] ? ~Y : Y) + op[0], truncated to WIDTH.
//  - Add overflow = X[msb]==Y[msb] && sum[msb]!=X[msb].
//    Sub overflow = X[msb]!=Y[msb] && sum[msb]!=X[msb].
//  - Sub of the most-negative Y follows the same rule; there is no special case.
//  - acc uses the value just written when ops are back-to-back. There is no
//    bypass hazard, because acc updates on the same edge as result.
//  - ovf_count: +1 on an accept whose overflow=1. It saturates at 2^CNT_W-1
//    and never wraps. clr_count has priority: clear with a simultaneous
//    overflow gives 0.
// CONFIGURATION
//  ARITH_SAT_EN defined: on overflow, result and acc clamp.
//    Positive overflow -> 0111..1. Negative overflow -> 1000..0.
//    overflow and ovf_count still report the event.
//  ARITH_SAT_EN undefined: result and acc wrap (truncated WIDTH-bit sum).
// TESTING  (WIDTH=8, CNT_W=2 unless noted)
//  1 Reset: reset_n=0 for 2 cycles with in_valid=1.
//    -> in_ready=0, out_valid=0, result=0, acc=0, ovf_count=0.
//  2 op=00 a=0x7F b=0x01.
//    -> next cycle result=0x80, ovf=1 (SAT_EN: result=0x7F, ovf=1).
//    op=01 a=0x80 b=0x01 -> 0x7F, ovf=1 (SAT_EN: 0x80).
//  3 Accumulate: op=00 a=5 b=3 -> 0x08. op=10 a=0xFE -> 0x06.
//    op=11 a=0x0A -> 0xFC, ovf=0. acc tracks each value.
//  4 Backpressure: out_ready=0, two ops issued.
//    -> first held stable, in_ready=0, second not accepted.
//    out_ready=1 -> pop+accept in same cycle, then one result/cycle.
//  5 ovf_count: 4 overflowing ops -> ovf_count=3 (saturated).
//    clr_count=1 with an overflowing accept -> ovf_count=0.
//  6 Reset asserted the cycle after an accept -> out_valid=0 and acc=0 next edge.
//    The result is never presented.

Source files
------------

// File: rtl/arith_accum_unit.sv
// Registered signed add/sub with running accumulator and saturating overflow-event counter.
// Latency 1 cycle, 1 op/cycle; in_ready drops while an unconsumed result is held (out_ready=0).
// Optional ARITH_SAT_EN: clamp result/acc on signed overflow instead of wrapping.
module arith_accum_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic [WIDTH-1:0] acc,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_count
);

    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] x, y, y_eff, sum, next_res;
    logic             next_ovf;
    logic             accept;

    assign in_ready = reset_n & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        x        = op[1] ? acc : a;
        y        = op[1] ? a : b;
        y_eff    = op[0] ? ~y : y;
        sum      = x + y_eff + {{(WIDTH-1){1'b0}}, op[0]};
        if (op[0])
            next_ovf = (x[WIDTH-1] != y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        else
            next_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
`ifdef ARITH_SAT_EN
        // Overflow direction always follows the sign of X for both add and sub.
        next_res = next_ovf ? (x[WIDTH-1] ? NEG_MIN : POS_MAX) : sum;
`else
        next_res = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            acc       <= '0;
            ovf_count <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                result    <= next_res;
                overflow  <= next_ovf;
                acc       <= next_res;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (clr_count)
                ovf_count <= '0;
            else if (accept && next_ovf && ovf_count != CNT_MAX)
                ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_arith_accum_unit.sv
// Bench for arith_accum_unit (WIDTH=8, CNT_W=2): vector table, hand sequences, random vs model.
module tb_arith_accum_unit;

    localparam int W    = 8;
    localparam int CW   = 2;
    localparam int MAXV = 2**(W-1) - 1;
    localparam int MINV = -(2**(W-1));
    localparam int CMAX = 2**CW - 1;

    logic          clk = 1'b0;
    logic          reset_n, in_valid, out_ready, clr_count;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          in_ready, out_valid, overflow;
    logic [W-1:0]  result, acc;
    logic [CW-1:0] ovf_count;

    int n_cmp = 0;
    int n_err = 0;

    arith_accum_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .acc(acc), .ovf_count(ovf_count),
        .clr_count(clr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: integer arithmetic, then range check and wrap/clamp.
    task automatic model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic [W-1:0] macc, output logic [W-1:0] mres, output logic movf);
        int x, y, full;
        x    = mop[1] ? int'($signed(macc)) : int'($signed(ma));
        y    = mop[1] ? int'($signed(ma))   : int'($signed(mb));
        full = mop[0] ? x - y : x + y;
        movf = (full > MAXV) || (full < MINV);
`ifdef ARITH_SAT_EN
        if (full > MAXV)      full = MAXV;
        else if (full < MINV) full = MINV;
`endif
        mres = W'(full);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b;
        logic [W-1:0] res_w;
        logic         ovf_w;
        logic [W-1:0] res_s;
        logic         ovf_s;
    } vec_t;

    vec_t vecs[10];

    logic         ev, eo, movf;
    logic [W-1:0] er, eacc, mres;
    int           ecnt;
    logic         exp_ovf;
    logic [W-1:0] exp_res;
    logic         rdy;

    initial begin
        vecs[0] = '{2'b00, 8'h7F, 8'h01, 8'h80, 1'b1, 8'h7F, 1'b1};
        vecs[1] = '{2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 8'h80, 1'b1};
        vecs[2] = '{2'b00, 8'h05, 8'h03, 8'h08, 1'b0, 8'h08, 1'b0};
        vecs[3] = '{2'b10, 8'hFE, 8'h55, 8'h06, 1'b0, 8'h06, 1'b0};
        vecs[4] = '{2'b11, 8'h0A, 8'hAA, 8'hFC, 1'b0, 8'hFC, 1'b0};
        vecs[5] = '{2'b01, 8'h00, 8'h80, 8'h80, 1'b1, 8'h7F, 1'b1};
        vecs[6] = '{2'b11, 8'h80, 8'h00, 8'h00, 1'b0, 8'h7F, 1'b1};
        vecs[7] = '{2'b10, 8'h01, 8'h00, 8'h01, 1'b0, 8'h7F, 1'b1};
        vecs[8] = '{2'b00, 8'h80, 8'h80, 8'h00, 1'b1, 8'h80, 1'b1};
        vecs[9] = '{2'b01, 8'h7F, 8'hFF, 8'h80, 1'b1, 8'h7F, 1'b1};

        // Reset with in_valid held high
        reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; clr_count = 1'b0;
        op = 2'b00; a = 8'h11; b = 8'h22;
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_acc", 32'(acc), 0);
        chk("rst_ovf_count", 32'(ovf_count), 0);
        reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Vector table, one accept per cycle
        ecnt = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
`ifdef ARITH_SAT_EN
            exp_res = vecs[i].res_s; exp_ovf = vecs[i].ovf_s;
`else
            exp_res = vecs[i].res_w; exp_ovf = vecs[i].ovf_w;
`endif
            tick();
            if (exp_ovf && ecnt < CMAX) ecnt++;
            chk($sformatf("vec%0d_result", i), 32'(result), 32'(exp_res));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(exp_ovf));
            chk($sformatf("vec%0d_acc", i), 32'(acc), 32'(exp_res));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 1);
            chk($sformatf("vec%0d_ovf_count", i), 32'(ovf_count), 32'(ecnt));
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", 32'(out_valid), 0);

        // Backpressure: hold first result, refuse second, then pop+accept
        out_ready = 1'b0; in_valid = 1'b1; op = 2'b00; a = 8'h01; b = 8'h02;
        tick();
        chk("bp_first_result", 32'(result), 32'h03);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        a = 8'h10; b = 8'h0E;
        tick();
        chk("bp_held_result", 32'(result), 32'h03);
        chk("bp_held_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", 32'(in_ready), 1);
        tick();
        chk("bp_pop_accept_result", 32'(result), 32'h1E);
        chk("bp_pop_accept_valid", 32'(out_valid), 1);
        a = 8'h10; b = 8'h01;
        tick();
        chk("bp_next_result", 32'(result), 32'h11);
        in_valid = 1'b0;
        tick();
        chk("bp_pop_valid", 32'(out_valid), 0);
        chk("bp_pop_result_kept", 32'(result), 32'h11);
        chk("bp_pop_acc_kept", 32'(acc), 32'h11);

        // Overflow counter saturation and clear priority
        clr_count = 1'b1;
        tick();
        chk("cnt_cleared", 32'(ovf_count), 0);
        clr_count = 1'b0; in_valid = 1'b1; op = 2'b00; a = 8'h7F; b = 8'h01;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("cnt_step%0d", i), 32'(ovf_count), 32'((i > CMAX) ? CMAX : i));
        end
        clr_count = 1'b1;
        tick();
        chk("cnt_clear_priority", 32'(ovf_count), 0);
        chk("cnt_clear_ovf_flag", 32'(overflow), 1);
        clr_count = 1'b0; in_valid = 1'b0;
        tick();

        // Reset right after an accept drops the in-flight result
        in_valid = 1'b1; op = 2'b00; a = 8'h21; b = 8'h01;
        tick();
        in_valid = 1'b0; reset_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 0);
        tick();
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_acc", 32'(acc), 0);
        chk("midrst_result", 32'(result), 0);
        reset_n = 1'b1;

        // Random traffic against the model
        ev = 1'b0; er = '0; eo = 1'b0; eacc = '0; ecnt = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_count = ($urandom_range(0, 15) == 0);
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (($urandom_range(0, 7)) == 0) a = 8'h80;
            #1;
            rdy = ~ev | out_ready;
            chk("rnd_in_ready", 32'(in_ready), 32'(rdy));
            model(op, a, b, eacc, mres, movf);
            if (in_valid && rdy) begin
                ev = 1'b1; er = mres; eo = movf; eacc = mres;
            end else if (out_ready) begin
                ev = 1'b0;
            end
            if (clr_count) ecnt = 0;
            else if (in_valid && rdy && movf && ecnt < CMAX) ecnt++;
            tick();
            chk("rnd_out_valid", 32'(out_valid), 32'(ev));
            chk("rnd_acc", 32'(acc), 32'(eacc));
            chk("rnd_ovf_count", 32'(ovf_count), 32'(ecnt));
            if (ev) begin
                chk("rnd_result", 32'(result), 32'(er));
                chk("rnd_overflow", 32'(overflow), 32'(eo));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
